count_display: RTL and testbench

Display-side consumer of the 8-bit counter value: converts a binary count to three BCD digits with a sequential double-dabble engine and drives a 4-digit, common-anode, multiplexed seven-segment display. It sits between the counter's `count` output and the board's segment/anode pins, refreshing the shown value whenever `update_e` is strobed.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/count_display.sv | 92 +++++++++
 tb/tb_count_display.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the count display: converter FSM states, segment
// codes and digit counts.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } bcd_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_BCD    = 3;
    localparam int BIN_WIDTH  = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8 shift cycles, then one latch cycle.
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for update_e; digit outputs hold the last result
//   ST_SHIFT | one add-3/shift iteration per cycle, 8 iterations total
//   ST_LATCH | copy accumulator to the digit outputs, back to idle
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BIN_WIDTH-1:0]     value,
    input  logic                     update_e,
    output logic                     busy,
    output logic [4*NUM_BCD-1:0]     bcd
);

    bcd_state_t              state, state_next;
    logic [BIN_WIDTH-1:0]    bin_sr;
    logic [4*NUM_BCD-1:0]    acc;
    logic [4*NUM_BCD-1:0]    acc_adj;
    logic [3:0]              iter;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (update_e) state_next = ST_SHIFT;
            ST_SHIFT: if (iter == 4'd7) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble ahead of the shift
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < NUM_BCD; i++)
            acc_adj[4*i +: 4] = add3(acc[4*i +: 4]);
    end

    // Shift datapath, iteration counter and result latch
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_sr <= '0;
            acc    <= '0;
            iter   <= '0;
            bcd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (update_e) begin
                        bin_sr <= value;
                        acc    <= '0;
                        iter   <= '0;
                    end
                end
                ST_SHIFT: begin
                    {acc, bin_sr} <= {acc_adj, bin_sr} << 1;
                    iter          <= iter + 4'd1;
                end
                ST_LATCH: bcd <= acc;
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/count_display.sv
// Multiplexed 4-digit common-anode seven-segment driver for an 8-bit count,
// with leading-zero blanking on the tens and hundreds digits.
module count_display
    import seg7_pkg::*;
#(
    parameter int COUNTER_WIDTH = 8,
    parameter int REFRESH_DIV   = 100000
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] value,
    input  logic                     update_e,
    output logic                     busy,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [NUM_DIGITS-1:0]    an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [4*NUM_BCD-1:0]  digits;
    logic [CNT_W-1:0]      refresh_cnt;
    logic [1:0]            scan_idx;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic [3:0]            d_ones, d_tens, d_hund;

    bin2bcd_seq u_bin2bcd (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .update_e (update_e),
        .busy     (busy),
        .bcd      (digits)
    );

    assign d_ones = digits[3:0];
    assign d_tens = digits[7:4];
    assign d_hund = digits[11:8];

    // Slot timer; the scan index advances each time the timer wraps
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Select, blank and decode the digit for the current slot
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = '1;
        case (scan_idx)
            2'd0: begin
                seg_next = seg_decode(d_ones);
                an_next  = 4'b1110;
            end
            2'd1: begin
                if (d_hund != 4'd0 || d_tens != 4'd0) begin
                    seg_next = seg_decode(d_tens);
                    an_next  = 4'b1101;
                end
            end
            2'd2: begin
                if (d_hund != 4'd0) begin
                    seg_next = seg_decode(d_hund);
                    an_next  = 4'b1011;
                end
            end
            default: ;
        endcase
    end

    // Registered pin drivers
    always_ff @(posedge clock) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with a short refresh divider.
module tb_count_display;

    localparam int RDIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       update_e;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int bc;

    logic [6:0] codes [10];
    logic [10:0] sb_q [$];

    count_display #(.COUNTER_WIDTH(8), .REFRESH_DIV(RDIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .update_e (update_e),
        .busy     (busy),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clock = ~clock;

    // Count of rising edges since reset was last released
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected {an,seg} for a displayed value in a given slot
    function automatic logic [10:0] exp_disp(input int v, input int idx);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (idx)
            0: return {4'b1110, codes[o]};
            1: return (h == 0 && t == 0) ? {4'b1111, 7'h7F} : {4'b1101, codes[t]};
            2: return (h == 0) ? {4'b1111, 7'h7F} : {4'b1011, codes[h]};
            default: return {4'b1111, 7'h7F};
        endcase
    endfunction

    // Push expectations for the next n cycles, then pop one per cycle
    task automatic scan(input int v, input int n, input string tag);
        logic [10:0] e;
        for (int k = 1; k <= n; k++)
            sb_q.push_back(exp_disp(v, ((cyc + k - 1) / RDIV) % 4));
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            chk({tag, "_an"},  32'(an),  32'(e[10:7]));
            chk({tag, "_seg"}, 32'(seg), 32'(e[6:0]));
        end
    endtask

    // Strobe update_e for one edge; returns just after that edge
    task automatic start(input logic [7:0] v);
        value    = v;
        update_e = 1'b1;
        @(negedge clock);
        update_e = 1'b0;
    endtask

    // Count busy samples until it drops, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        reset    = 1'b1;
        value    = '0;
        update_e = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_seg",  32'(seg),  32'h7F);
        chk("rst_an",   32'(an),   32'hF);
        chk("rst_dp",   32'(dp),   32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        reset = 1'b0;
        @(negedge clock);
        chk("first_an",  32'(an),  32'hE);
        chk("first_seg", 32'(seg), 32'h40);
        scan(0, 20, "idle_scan");

        start(8'd255);
        wait_done(bc);
        chk("busy_len_255", 32'(bc), 32'd9);
        @(negedge clock);
        scan(255, 16, "d255");

        start(8'd7);
        wait_done(bc);
        chk("busy_len_7", 32'(bc), 32'd9);
        @(negedge clock);
        scan(7, 16, "d7");

        start(8'd105);
        wait_done(bc);
        @(negedge clock);
        scan(105, 16, "d105");

        // Second strobe while busy is dropped; strobe at E10 is taken
        start(8'd99);
        repeat (3) @(negedge clock);
        start(8'd200);
        wait_done(bc);
        chk("busy_after_e4", 32'(bc), 32'd5);
        start(8'd200);
        chk("e10_accept", 32'(busy), 32'h1);
        scan(99, 8, "d99");
        wait_done(bc);
        chk("busy_tail_200", 32'(bc), 32'd1);
        @(negedge clock);
        scan(200, 16, "d200");

        // Reset in the middle of a conversion
        start(8'd123);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_seg",  32'(seg),  32'h7F);
        chk("abort_an",   32'(an),   32'hF);
        chk("abort_dp",   32'(dp),   32'h1);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_rel_an",  32'(an),  32'hE);
        chk("abort_rel_seg", 32'(seg), 32'h40);
        scan(0, 16, "abort_scan");

        // Reset wins over a simultaneous update strobe
        value    = 8'd55;
        update_e = 1'b1;
        reset    = 1'b1;
        @(negedge clock);
        update_e = 1'b0;
        reset    = 1'b0;
        chk("rst_upd_busy0", 32'(busy), 32'h0);
        @(negedge clock);
        chk("rst_upd_busy1", 32'(busy), 32'h0);
        scan(0, 16, "rst_upd_scan");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
